// File: rtl/instr_mem_loader.sv
// Instruction-memory writer: assembles little-endian words from a host byte
// stream, writes them sequentially and commits the block count on a sample tick.
module instr_mem_loader #(
  parameter int n_blocks = 256,
  localparam int AW = $clog2(n_blocks)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [7:0]    in_byte,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          sample_tick,
  output logic [AW-1:0] instr_write_addr,
  output logic [31:0]   instr_write_val,
  output logic          instr_write_enable,
  output logic [AW-1:0] n_blocks_running,
  output logic [AW-1:0] last_block,
  output logic          fetch_enable,
  output logic          fetch_reset,
  output logic          busy,
  output logic          error
);

  localparam logic [7:0] CMD_LOAD  = 8'h01;
  localparam logic [7:0] CMD_CLEAR = 8'h02;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_DATA,
    S_WAIT_TICK,
    S_COMMIT
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] n_q, n_d;
  logic [AW-1:0] word_q, word_d;
  logic [1:0]    byte_q, byte_d;
  logic [23:0]   asm_q, asm_d;
  logic          we_q, we_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [31:0]   wval_q, wval_d;
  logic [AW-1:0] nrun_q, nrun_d;
  logic [AW-1:0] last_q, last_d;
  logic          fen_q, fen_d;
  logic          frst_q, frst_d;
  logic          err_q, err_d;

  logic accept;
  logic count_bad;

  assign in_ready  = (state_q == S_IDLE) || (state_q == S_COUNT) || (state_q == S_DATA);
  assign accept    = in_valid && in_ready;
  assign count_bad = (in_byte == 8'd0) || ({24'd0, in_byte} >= 32'(n_blocks));

  always_comb begin
    // NOTE: every variable gets its default first so no path leaves it unassigned (no latches).
    state_d = state_q;
    n_d     = n_q;
    word_d  = word_q;
    byte_d  = byte_q;
    asm_d   = asm_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wval_d  = wval_q;
    nrun_d  = nrun_q;
    last_d  = last_q;
    fen_d   = fen_q;
    frst_d  = 1'b0;
    err_d   = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (in_byte == CMD_LOAD) begin
            state_d = S_COUNT;
            fen_d   = 1'b0;
            err_d   = 1'b0;
          end else if (in_byte == CMD_CLEAR) begin
            state_d = S_WAIT_TICK;
            n_d     = '0;
            fen_d   = 1'b0;
            err_d   = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_COUNT: begin
        if (accept) begin
          if (count_bad) begin
            // Rejected header: the previous program keeps running untouched.
            state_d = S_IDLE;
            err_d   = 1'b1;
            fen_d   = 1'b1;
          end else begin
            state_d = S_DATA;
            n_d     = AW'(in_byte);
            word_d  = '0;
            byte_d  = '0;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          byte_d = byte_q + 2'd1;
          unique case (byte_q)
            2'd0: asm_d[7:0]   = in_byte;
            2'd1: asm_d[15:8]  = in_byte;
            2'd2: asm_d[23:16] = in_byte;
            2'd3: begin
              we_d    = 1'b1;
              waddr_d = word_q;
              wval_d  = {in_byte, asm_q};
              word_d  = word_q + AW'(1);
              if (word_q == n_q - AW'(1)) state_d = S_WAIT_TICK;
            end
          endcase
        end
      end
      S_WAIT_TICK: begin
        if (sample_tick) begin
          state_d = S_COMMIT;
          frst_d  = 1'b1;
          nrun_d  = n_q;
          last_d  = (n_q == '0) ? '0 : n_q - AW'(1);
        end
      end
      S_COMMIT: begin
        state_d = S_IDLE;
        fen_d   = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      word_q  <= '0;
      byte_q  <= '0;
      asm_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wval_q  <= '0;
      nrun_q  <= '0;
      last_q  <= '0;
      fen_q   <= 1'b1;
      frst_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      n_q     <= n_d;
      word_q  <= word_d;
      byte_q  <= byte_d;
      asm_q   <= asm_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wval_q  <= wval_d;
      nrun_q  <= nrun_d;
      last_q  <= last_d;
      fen_q   <= fen_d;
      frst_q  <= frst_d;
      err_q   <= err_d;
    end
  end

  assign instr_write_enable = we_q;
  assign instr_write_addr   = waddr_q;
  assign instr_write_val    = wval_q;
  assign n_blocks_running   = nrun_q;
  assign last_block         = last_q;
  assign fetch_enable       = fen_q;
  assign fetch_reset        = frst_q;
  assign error              = err_q;
  assign busy               = (state_q != S_IDLE);

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader: the driver predicts write strobes and
// commits from the frame contents; a negedge monitor pops and compares them.
module tb_instr_mem_loader;

  localparam int NB = 256;
  localparam int AW = $clog2(NB);

  logic          clk = 1'b0;
  logic          reset_n;
  logic [7:0]    in_byte;
  logic          in_valid;
  logic          in_ready;
  logic          sample_tick;
  logic [AW-1:0] instr_write_addr;
  logic [31:0]   instr_write_val;
  logic          instr_write_enable;
  logic [AW-1:0] n_blocks_running;
  logic [AW-1:0] last_block;
  logic          fetch_enable;
  logic          fetch_reset;
  logic          busy;
  logic          error;

  instr_mem_loader #(.n_blocks(NB)) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .in_byte            (in_byte),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .sample_tick        (sample_tick),
    .instr_write_addr   (instr_write_addr),
    .instr_write_val    (instr_write_val),
    .instr_write_enable (instr_write_enable),
    .n_blocks_running   (n_blocks_running),
    .last_block         (last_block),
    .fetch_enable       (fetch_enable),
    .fetch_reset        (fetch_reset),
    .busy               (busy),
    .error              (error)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   val;
    int unsigned   cyc;
  } wr_t;

  typedef struct {
    logic [AW-1:0] n;
    logic [AW-1:0] last;
    int unsigned   cyc;
  } cm_t;

  wr_t wr_q[$];
  cm_t cm_q[$];

  // Reference model: a finished frame leaves a count waiting for the next tick.
  bit          pending = 0;
  int          pend_n  = 0;
  logic [31:0] ld_words[$];
  bit          after_commit = 0;

  always @(negedge clk) begin
    if (reset_n) begin
      if (instr_write_enable) begin
        if (wr_q.size() == 0) begin
          check("unexpected_write_strobe", 32'd1, 32'd0);
        end else begin
          wr_t e;
          e = wr_q.pop_front();
          check("write_addr", 32'(instr_write_addr), 32'(e.addr));
          check("write_val", instr_write_val, e.val);
          check("write_cycle", cyc, e.cyc);
        end
      end
      if (fetch_reset) begin
        if (cm_q.size() == 0) begin
          check("unexpected_fetch_reset", 32'd1, 32'd0);
        end else begin
          cm_t c;
          c = cm_q.pop_front();
          check("commit_n_running", 32'(n_blocks_running), 32'(c.n));
          check("commit_last_block", 32'(last_block), 32'(c.last));
          check("commit_cycle", cyc, c.cyc);
          check("commit_fetch_enable_low", 32'(fetch_enable), 32'd0);
        end
        after_commit = 1;
      end else if (after_commit) begin
        check("post_commit_fetch_enable", 32'(fetch_enable), 32'd1);
        check("post_commit_idle", 32'(busy), 32'd0);
        after_commit = 0;
      end
    end
  end

  // Presents one byte; hs returns the cycle count seen just before the handshake edge.
  task automatic send_byte(input logic [7:0] b, input bit tick, output int unsigned hs);
    int waited = 0;
    @(negedge clk);
    in_byte     = b;
    in_valid    = 1'b1;
    sample_tick = tick;
    #1;
    while (!in_ready && waited < 200) begin
      sample_tick = 1'b0;
      @(negedge clk);
      #1;
      waited++;
    end
    hs = cyc;
    if (!in_ready) begin
      check("in_ready_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid    = 1'b0;
    sample_tick = 1'b0;
  endtask

  task automatic send_load(input bit tick_last, input int gap_at, input int gap_len, input int rand_gap);
    int unsigned hs;
    int          n;
    logic [31:0] w;
    n = ld_words.size();
    send_byte(8'h01, 1'b0, hs);
    check("cmd_fetch_enable_low", 32'(fetch_enable), 32'd0);
    check("cmd_error_clear", 32'(error), 32'd0);
    send_byte(8'(n), 1'b0, hs);
    for (int i = 0; i < n; i++) begin
      w = ld_words[i];
      for (int k = 0; k < 4; k++) begin
        int idle;
        idle = (i * 4 + k == gap_at) ? gap_len : ((rand_gap > 0) ? int'($urandom_range(rand_gap, 0)) : 0);
        repeat (idle) @(negedge clk);
        send_byte(w[8*k +: 8], tick_last && (i == n - 1) && (k == 3), hs);
        if (k == 3) wr_q.push_back('{addr: AW'(i), val: w, cyc: hs + 1});
      end
    end
    pending = 1;
    pend_n  = n;
  endtask

  task automatic send_clear(input bit tick);
    int unsigned hs;
    send_byte(8'h02, tick, hs);
    check("clear_fetch_enable_low", 32'(fetch_enable), 32'd0);
    pending = 1;
    pend_n  = 0;
  endtask

  task automatic send_tick();
    @(negedge clk);
    sample_tick = 1'b1;
    #1;
    if (pending) begin
      cm_q.push_back('{n: AW'(pend_n), last: (pend_n == 0) ? '0 : AW'(pend_n - 1), cyc: cyc + 1});
      pending = 0;
    end
    @(posedge clk);
    #1;
    sample_tick = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_fetch_enable"}, 32'(fetch_enable), 32'd1);
    check({tag, "_fetch_reset"}, 32'(fetch_reset), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
    check({tag, "_write_enable"}, 32'(instr_write_enable), 32'd0);
    check({tag, "_n_running"}, 32'(n_blocks_running), 32'd0);
    check({tag, "_last_block"}, 32'(last_block), 32'd0);
  endtask

  initial begin
    int unsigned hs;
    reset_n     = 1'b0;
    in_byte     = 8'h00;
    in_valid    = 1'b0;
    sample_tick = 1'b0;
    #17;
    check_reset_vals("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // Basic two-word load.
    ld_words = '{32'h12345678, 32'hDEADBEEF};
    send_load(1'b0, -1, 0, 0);
    check("pre_commit_n_running", 32'(n_blocks_running), 32'd0);
    send_tick();

    // Tick coinciding with the last data byte must be ignored.
    ld_words = '{32'hCAFEF00D, 32'h0BADC0DE};
    send_load(1'b1, -1, 0, 0);
    repeat (5) @(negedge clk);
    check("late_tick_fetch_enable", 32'(fetch_enable), 32'd0);
    check("late_tick_busy", 32'(busy), 32'd1);
    check("late_tick_n_running", 32'(n_blocks_running), 32'd2);
    send_tick();

    // Three words, then CLEAR with a same-cycle tick that must be ignored.
    ld_words = '{$urandom, $urandom, $urandom};
    send_load(1'b0, -1, 0, 1);
    send_tick();
    send_clear(1'b1);
    repeat (3) @(negedge clk);
    check("clear_wait_fetch_enable", 32'(fetch_enable), 32'd0);
    check("clear_wait_n_running", 32'(n_blocks_running), 32'd3);
    send_tick();

    // Protocol errors.
    send_byte(8'h7F, 1'b0, hs);
    check("bad_cmd_error", 32'(error), 32'd1);
    check("bad_cmd_busy", 32'(busy), 32'd0);
    check("bad_cmd_fetch_enable", 32'(fetch_enable), 32'd1);
    send_byte(8'h01, 1'b0, hs);
    check("load_hdr_error_clear", 32'(error), 32'd0);
    send_byte(8'h00, 1'b0, hs);
    check("zero_count_error", 32'(error), 32'd1);
    check("zero_count_fetch_enable", 32'(fetch_enable), 32'd1);
    check("zero_count_busy", 32'(busy), 32'd0);
    check("zero_count_n_running", 32'(n_blocks_running), 32'd0);

    // Valid load with in_valid dropped for 5 cycles between bytes 2 and 3.
    ld_words = '{32'hA5B6C7D8};
    send_load(1'b0, 3, 5, 0);
    send_tick();

    // Reset in the middle of a two-word load after 6 bytes.
    send_byte(8'h01, 1'b0, hs);
    send_byte(8'h02, 1'b0, hs);
    begin
      logic [31:0] w;
      w = 32'h44332211;
      for (int k = 0; k < 4; k++) begin
        send_byte(w[8*k +: 8], 1'b0, hs);
        if (k == 3) wr_q.push_back('{addr: AW'(0), val: w, cyc: hs + 1});
      end
    end
    send_byte(8'h55, 1'b0, hs);
    send_byte(8'h66, 1'b0, hs);
    check("mid_frame_busy", 32'(busy), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_vals("mid_reset");
    pending = 0;
    @(negedge clk);
    reset_n = 1'b1;
    ld_words = '{32'h0F1E2D3C};
    send_load(1'b0, -1, 0, 0);
    send_tick();
    check("fresh_load_n_running", 32'(n_blocks_running), 32'd1);

    // Randomized frames with random gaps and late ticks.
    for (int it = 0; it < 10; it++) begin
      if ($urandom_range(3, 0) == 0) begin
        send_clear(1'($urandom_range(1, 0)));
      end else begin
        int n;
        n = int'($urandom_range(6, 1));
        ld_words.delete();
        for (int i = 0; i < n; i++) ld_words.push_back($urandom);
        send_load(1'($urandom_range(1, 0)), -1, 0, 2);
      end
      repeat ($urandom_range(3, 0)) @(negedge clk);
      send_tick();
    end

    repeat (5) @(negedge clk);
    check("writes_outstanding", 32'(wr_q.size()), 32'd0);
    check("commits_outstanding", 32'(cm_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
